decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  IF/ID pipeline stage of the RV32I core; sits directly upstream of immGen and the regfile read.
//  Buffers fetched {pc, inst} beats in a 2-entry skid buffer with valid/ready handshakes.
//  Decodes the head entry into imm_sel (drives immGen), register indices and basic control.
//  Applies the load-use interlock and branch/jump flush before beats move to execute.
// PARAMETERS
//  RESET_PC   32'h0000_2000  pc value loaded into the head entry on reset
//  NOP_INST   32'h0000_0013  instruction loaded into the head entry on reset or kill (addi x0,x0,0)
// PORTS
//  clk            in   1   single core clock; all state updates on rising edge
//  reset          in   1   synchronous, active-high reset
//  in_valid       in   1   fetch presents a beat
//  in_ready       out  1   stage accepts a beat this cycle
//  in_inst        in   32  fetched instruction
//  in_pc          in   32  pc of in_inst
//  kill           in   1   flush from execute (taken branch/jump); drops all buffered beats
//  ex_load_valid  in   1   instruction in execute is a valid load
//  ex_rd          in   5   destination register of that load
//  out_valid      out  1   head beat valid and not interlocked
//  out_ready      in   1   execute accepts the head beat
//  out_inst       out  32  head instruction (also drives immGen.inst)
//  out_pc         out  32  head pc
//  imm_sel        out  5   immediate format for immGen
//  rs1, rs2, rd   out  5   inst[19:15], inst[24:20], inst[11:7] of head
//  rs1_used       out  1   head reads rs1
//  rs2_used       out  1   head reads rs2
//  reg_we         out  1   head writes rd (forced 0 when rd==0)
//  illegal        out  1   head opcode not in the supported RV32I set
// BEHAVIOUR
//  Reset (sync): head/skid valid=0; head inst=NOP_INST, pc=RESET_PC; out_valid=0, in_ready=1 next cycle.
//  Buffer: entries HEAD and SKID. in_ready = !skid_valid (registered state only, no comb path from out_ready).
//   Accept when in_valid&&in_ready; fires out when out_valid&&out_ready.
//   Empty: accept -> HEAD. Head only: accept & fire -> HEAD replaced; accept & no fire -> SKID.
//   Full: fire -> SKID moves to HEAD, SKID empties; no accept possible.
//  Latency: beat accepted at cycle N is visible on out_* at N+1 (buffer empty case); 1 beat/cycle throughput.
//  Ordering strictly FIFO; no beat duplicated or lost except by kill.
//  Kill: next cycle both entries invalid, head inst=NOP_INST; a beat offered in the kill cycle is dropped
//   (kill beats accept); kill has priority over reset-free fire/accept; reset has priority over kill.
//  Interlock: hazard = head_valid && ex_load_valid && ex_rd!=0 &&
//   ((rs1_used && rs1==ex_rd) || (rs2_used && rs2==ex_rd)). hazard -> out_valid=0, head held.
//  out_valid = head_valid && !hazard. Decode outputs are combinational from HEAD regardless of valid.
//  imm_sel codes (shared with immGen): S=0 B=1 U=2 J=3 I=4 I_STAR=5.
//   LOAD 0000011, JALR 1100111 -> I; OP-IMM 0010011 -> I_STAR if funct3 in {001,101}, else I;
//   STORE 0100011 -> S; BRANCH 1100011 -> B; LUI 0110111, AUIPC 0010111 -> U; JAL 1101111 -> J;
//   OP 0110011, SYSTEM 1110011, illegal -> I (value unused downstream).
//  rs1_used: all except LUI/AUIPC/JAL. rs2_used: OP, STORE, BRANCH. reg_we: all except STORE/BRANCH, rd!=0.
//  illegal=1 for any other opcode or inst[1:0]!=2'b11; beat still passes (execute traps/ignores).
// STRUCTURE
//  Shared package/header: opcode constants, IMM_S/B/U/J/I/I_STAR codes (single source for this block
//   and immGen), NOP_INST.
//  Sub-module: skid_buffer #(W=64) holding {pc,inst}, with kill input; decode + interlock are comb logic here.
// TESTING
//  Reset then in_valid with inst=0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1,
//   imm_sel=4, rd=1, rs1_used=1, rs2_used=0, reg_we=1.
//  Stream 0x00209093 (slli), 0x00112223 (sw), 0x00208663 (beq), 0x000012b7 (lui), 0x008000ef (jal)
//   -> imm_sel 5,0,1,2,3 in order, one per cycle.
//  out_ready=0 while 3 beats offered -> 2 accepted, in_ready=0 after second; release -> FIFO order kept.
//  Buffer full, kill=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_inst=0x00000013.
//  ex_load_valid=1, ex_rd=2, head=add x3,x2,x1 (0x001101b3) -> out_valid=0 held; ex_load_valid=0 -> fires.
//  Same with ex_rd=0 or head=lui x2 -> no stall; inst=0xffffffff -> illegal=1.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode constants: opcodes, immGen format codes, NOP and the
// per-opcode control decode used by the IF/ID stage.
package decode_stage_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Immediate format codes, shared with immGen.
    localparam logic [4:0] IMM_S      = 5'd0;
    localparam logic [4:0] IMM_B      = 5'd1;
    localparam logic [4:0] IMM_U      = 5'd2;
    localparam logic [4:0] IMM_J      = 5'd3;
    localparam logic [4:0] IMM_I      = 5'd4;
    localparam logic [4:0] IMM_I_STAR = 5'd5;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_2000;

    typedef struct packed {
        logic [4:0] imm_sel;
        logic       rs1_used;
        logic       rs2_used;
        logic       writes_rd;
        logic       illegal;
    } dec_t;

    function automatic dec_t decode_inst(input logic [6:0] opcode, input logic [2:0] funct3);
        dec_t d;
        d.imm_sel   = IMM_I;
        d.rs1_used  = 1'b1;
        d.rs2_used  = 1'b0;
        d.writes_rd = 1'b1;
        d.illegal   = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR, OPC_OP, OPC_SYSTEM: ;
            OPC_OP_IMM: if (funct3 == 3'b001 || funct3 == 3'b101) d.imm_sel = IMM_I_STAR;
            OPC_STORE: begin
                d.imm_sel   = IMM_S;
                d.rs2_used  = 1'b1;
                d.writes_rd = 1'b0;
            end
            OPC_BRANCH: begin
                d.imm_sel   = IMM_B;
                d.rs2_used  = 1'b1;
                d.writes_rd = 1'b0;
            end
            OPC_LUI, OPC_AUIPC: begin
                d.imm_sel  = IMM_U;
                d.rs1_used = 1'b0;
            end
            OPC_JAL: begin
                d.imm_sel  = IMM_J;
                d.rs1_used = 1'b0;
            end
            default: d.illegal = 1'b1;
        endcase
        // OP's second source is picked up here so the case above stays one line per group.
        if (opcode == OPC_OP) d.rs2_used = 1'b1;
        return d;
    endfunction

endpackage

// File: rtl/decode_stage_skid_buffer.sv
// Two-entry (HEAD + SKID) valid/ready buffer. in_ready depends only on
// registered state; kill empties both entries and overwrites the head's low field.
module skid_buffer #(
    parameter int             W          = 64,
    parameter int             LO_W       = 32,
    parameter logic [W-1:0]   RESET_DATA = '0,
    parameter logic [LO_W-1:0] KILL_LO   = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         kill,
    input  logic         pop,
    output logic         head_valid,
    output logic [W-1:0] head_data
);

    logic         head_valid_q, head_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] head_data_q, head_data_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         push, take;

    assign push       = in_valid && !skid_valid_q;
    assign take       = pop && head_valid_q;
    assign in_ready   = !skid_valid_q;
    assign head_valid = head_valid_q;
    assign head_data  = head_data_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;
        head_data_d  = head_data_q;
        skid_data_d  = skid_data_q;
        if (kill) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            head_data_d  = {head_data_q[W-1:LO_W], KILL_LO};
        end else if (skid_valid_q) begin
            if (take) begin
                head_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (head_valid_q) begin
            if (take && push) begin
                head_data_d = in_data;
            end else if (take) begin
                head_valid_d = 1'b0;
            end else if (push) begin
                skid_data_d  = in_data;
                skid_valid_d = 1'b1;
            end
        end else if (push) begin
            head_data_d  = in_data;
            head_valid_d = 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            head_data_q  <= RESET_DATA;
        end else begin
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            head_data_q  <= head_data_d;
        end
    end

    // NOTE: skid payload is never reset; it is only observed once skid_valid_q marks it written.
    always_ff @(posedge clk) begin
        skid_data_q <= skid_data_d;
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I IF/ID stage: buffers {pc, inst} beats, decodes the head entry for
// immGen/regfile, and applies the load-use interlock and execute flush.
module decode_stage #(
    parameter logic [31:0] RESET_PC = decode_stage_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = decode_stage_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    input  logic        kill,
    input  logic        ex_load_valid,
    input  logic [4:0]  ex_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [4:0]  imm_sel,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        rs1_used,
    output logic        rs2_used,
    output logic        reg_we,
    output logic        illegal
);
    import decode_stage_pkg::dec_t;
    import decode_stage_pkg::decode_inst;

    logic        head_valid;
    logic [63:0] head_data;
    logic        hazard;
    dec_t        dec;

    skid_buffer #(
        .W         (64),
        .LO_W      (32),
        .RESET_DATA({RESET_PC, NOP_INST}),
        .KILL_LO   (NOP_INST)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_pc, in_inst}),
        .kill      (kill),
        .pop       (out_valid && out_ready),
        .head_valid(head_valid),
        .head_data (head_data)
    );

    assign out_pc   = head_data[63:32];
    assign out_inst = head_data[31:0];
    assign rs1      = out_inst[19:15];
    assign rs2      = out_inst[24:20];
    assign rd       = out_inst[11:7];

    assign dec      = decode_inst(out_inst[6:0], out_inst[14:12]);
    assign imm_sel  = dec.imm_sel;
    assign rs1_used = dec.rs1_used;
    assign rs2_used = dec.rs2_used;
    assign reg_we   = dec.writes_rd && (rd != 5'd0);
    assign illegal  = dec.illegal;

    // A load's result is not forwardable yet, so a dependent head must wait one cycle in place.
    assign hazard = head_valid && ex_load_valid && (ex_rd != 5'd0) &&
                    ((rs1_used && rs1 == ex_rd) || (rs2_used && rs2 == ex_rd));

    assign out_valid = head_valid && !hazard;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, kill, ex_load_valid, out_valid, out_ready;
    logic        rs1_used, rs2_used, reg_we, illegal;
    logic [31:0] in_inst, in_pc, out_inst, out_pc;
    logic [4:0]  ex_rd, imm_sel, rs1, rs2, rd;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    logic [63:0] q[$];

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .kill(kill), .ex_load_valid(ex_load_valid),
        .ex_rd(ex_rd), .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .imm_sel(imm_sel), .rs1(rs1), .rs2(rs2), .rd(rd),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .reg_we(reg_we), .illegal(illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [4:0] imm;
        bit r1u, r2u, we, ill;
    } exp_dec_t;

    // Reference decode written straight from the instruction-class rules.
    function automatic exp_dec_t ref_decode(input logic [31:0] i);
        exp_dec_t e;
        logic [6:0] op = i[6:0];
        bit is_store  = (op == 7'h23);
        bit is_branch = (op == 7'h63);
        bit is_upper  = (op == 7'h37) || (op == 7'h17);
        bit is_jal    = (op == 7'h6f);
        bit is_opimm  = (op == 7'h13);
        bit is_op     = (op == 7'h33);
        bit known     = is_store || is_branch || is_upper || is_jal || is_opimm || is_op ||
                        op == 7'h03 || op == 7'h67 || op == 7'h73;
        e.ill = !known;
        if (is_store)                                          e.imm = 5'd0;
        else if (is_branch)                                    e.imm = 5'd1;
        else if (is_upper)                                     e.imm = 5'd2;
        else if (is_jal)                                       e.imm = 5'd3;
        else if (is_opimm && (i[14:12] == 3'd1 || i[14:12] == 3'd5)) e.imm = 5'd5;
        else                                                   e.imm = 5'd4;
        e.r1u = !(is_upper || is_jal);
        e.r2u = is_op || is_store || is_branch;
        e.we  = !(is_store || is_branch) && (i[11:7] != 5'd0);
        return e;
    endfunction

    // Compare process: check outputs against the model, then advance the model with this cycle's inputs.
    exp_dec_t  m_dec;
    bit        m_hv, m_hazard, m_fire, m_accept;
    logic [31:0] m_inst;
    always @(negedge clk) begin
        m_hv     = (q.size() > 0);
        m_inst   = m_hv ? q[0][31:0] : 32'h0;
        m_dec    = ref_decode(m_inst);
        m_hazard = m_hv && ex_load_valid && ex_rd != 5'd0 &&
                   ((m_dec.r1u && m_inst[19:15] == ex_rd) || (m_dec.r2u && m_inst[24:20] == ex_rd));
        if (started && !reset) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, m_hv && !m_hazard});
            check("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
            if (m_hv) begin
                check("out_inst", out_inst, m_inst);
                check("out_pc", out_pc, q[0][63:32]);
                check("imm_sel", {27'd0, imm_sel}, {27'd0, m_dec.imm});
                check("regs", {17'd0, rs1, rs2, rd}, {17'd0, m_inst[19:15], m_inst[24:20], m_inst[11:7]});
                check("ctrl", {28'd0, rs1_used, rs2_used, reg_we, illegal},
                      {28'd0, m_dec.r1u, m_dec.r2u, m_dec.we, m_dec.ill});
            end
        end
        m_fire   = m_hv && !m_hazard && out_ready;
        m_accept = in_valid && (q.size() < 2);
        if (reset || kill) begin
            q.delete();
        end else begin
            if (m_fire) void'(q.pop_front());
            if (m_accept) q.push_back({in_pc, in_inst});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] inst);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = in_pc + 32'd4;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] i = $urandom;
        case ($urandom_range(0, 10))
            0: i[6:0] = 7'h03;  1: i[6:0] = 7'h13;  2: i[6:0] = 7'h17;
            3: i[6:0] = 7'h23;  4: i[6:0] = 7'h33;  5: i[6:0] = 7'h37;
            6: i[6:0] = 7'h63;  7: i[6:0] = 7'h67;  8: i[6:0] = 7'h6f;
            9: i[6:0] = 7'h73;  default: ;
        endcase
        i[11:7]  = 5'($urandom_range(0, 3));
        i[19:15] = 5'($urandom_range(0, 3));
        i[24:20] = 5'($urandom_range(0, 3));
        return i;
    endfunction

    logic [31:0] stream[5];
    logic [4:0]  stream_sel[5];

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_inst = 32'h0; in_pc = 32'h100; kill = 1'b0;
        ex_load_valid = 1'b0; ex_rd = 5'd0; out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        started = 1'b1;
        @(negedge clk);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_inst", out_inst, 32'h0000_0013);
        check("reset out_pc", out_pc, 32'h0000_2000);

        // addi x1, x0, 5
        tick();
        offer(32'h0050_0093);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("addi out_valid", {31'd0, out_valid}, 32'd1);
        check("addi imm_sel", {27'd0, imm_sel}, 32'd4);
        check("addi rd", {27'd0, rd}, 32'd1);
        check("addi ctrl", {29'd0, rs1_used, rs2_used, reg_we}, 32'b101);
        tick();

        // back-to-back stream: slli, sw, beq, lui, jal
        stream = '{32'h0020_9093, 32'h0011_2223, 32'h0020_8663, 32'h0000_12b7, 32'h0080_00ef};
        stream_sel = '{5'd5, 5'd0, 5'd1, 5'd2, 5'd3};
        offer(stream[0]);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i < 4) offer(stream[i+1]);
            else in_valid = 1'b0;
            @(negedge clk);
            check("stream imm_sel", {27'd0, imm_sel}, {27'd0, stream_sel[i]});
            check("stream out_inst", out_inst, stream[i]);
        end
        tick();

        // backpressure: three offered, two held, FIFO order on release
        out_ready = 1'b0;
        offer(32'h0010_0093);
        tick();
        offer(32'h0020_0113);
        tick();
        offer(32'h0030_0193);
        @(negedge clk);
        check("bp full in_ready", {31'd0, in_ready}, 32'd0);
        check("bp head", out_inst, 32'h0010_0093);
        tick();
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("bp second", out_inst, 32'h0020_0113);
        check("bp in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp third", out_inst, 32'h0030_0193);
        tick();

        // kill with buffer full and a beat offered
        out_ready = 1'b0;
        offer(32'h0040_0213);
        tick();
        offer(32'h0050_0293);
        tick();
        offer(32'h0060_0313);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("kill out_valid", {31'd0, out_valid}, 32'd0);
        check("kill in_ready", {31'd0, in_ready}, 32'd1);
        check("kill out_inst", out_inst, 32'h0000_0013);
        tick();
        out_ready = 1'b1;

        // load-use interlock: add x3, x2, x1 behind a load to x2
        ex_load_valid = 1'b1;
        ex_rd = 5'd2;
        offer(32'h0011_01b3);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("hazard stall", {31'd0, out_valid}, 32'd0);
        tick();
        @(negedge clk);
        check("hazard held", out_inst, 32'h0011_01b3);
        tick();
        ex_load_valid = 1'b0;
        @(negedge clk);
        check("hazard release", {31'd0, out_valid}, 32'd1);
        tick();
        @(negedge clk);
        check("hazard fired", {31'd0, out_valid}, 32'd0);

        // ex_rd == 0 never stalls
        tick();
        ex_load_valid = 1'b1;
        ex_rd = 5'd0;
        offer(32'h0011_01b3);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("x0 no stall", {31'd0, out_valid}, 32'd1);
        tick();

        // lui x2 does not read registers
        ex_rd = 5'd2;
        offer(32'h0000_2137);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("lui no stall", {31'd0, out_valid}, 32'd1);
        tick();
        ex_load_valid = 1'b0;

        offer(32'hffff_ffff);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("illegal flag", {31'd0, illegal}, 32'd1);
        check("illegal passes", {31'd0, out_valid}, 32'd1);
        tick();

        // randomized traffic, checked cycle by cycle by the compare process
        for (int c = 0; c < 3000; c++) begin
            in_valid      = ($urandom_range(0, 1) == 1);
            in_inst       = rand_inst();
            in_pc         = $urandom;
            out_ready     = ($urandom_range(0, 9) < 7);
            kill          = ($urandom_range(0, 29) == 0);
            reset         = ($urandom_range(0, 99) == 0);
            ex_load_valid = ($urandom_range(0, 9) < 3);
            ex_rd         = 5'($urandom_range(0, 3));
            tick();
        end
        reset = 1'b0; kill = 1'b0; in_valid = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
